// File: rtl/shift_add_datapath.sv
// shift_add_datapath
//   Datapath for the sequential shift-add multiplier. It is controlled by the
//   multiplier FSM and returns `done` to it. It holds the operand registers,
//   the accumulator (carry in the MSB), the lower multiplier/product register,
//   the iteration counter and the held result.
//
//   Optional build macro: SIGNED_OPERANDS_EN
//     defined   - a_in/b_in are two's complement. Magnitudes are multiplied,
//                 and the captured product is negated when the signs differ.
//     undefined - operands are unsigned.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high clear of acc/lo/cnt
//   enableFFin  in   capture a_in/b_in (also accepted while rst is high)
//   enableFijo  in   init: lo <= multiplier, acc <= 0, cnt <= 0
//   load        in   conditional add of the multiplicand into acc
//   shift       in   shift {acc,lo} right by one, count the iteration
//   a_in        in   multiplicand [WIDTH]
//   b_in        in   multiplier   [WIDTH]
//   done        out  last iteration in progress (cnt == WIDTH-1)
//   product     out  held result of the last completed multiply [2*WIDTH]

module shift_add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enableFFin,
  input  logic               enableFijo,
  input  logic               load,
  input  logic               shift,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   lo;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] post_shift;
  logic [2*WIDTH-1:0] result;
  logic               capture;

`ifdef SIGNED_OPERANDS_EN
  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  logic neg_r;

  // The most negative input maps to 2^(WIDTH-1). That value still fits
  // in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + ONE_W) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (enableFFin) begin
      a_r   <= magnitude(a_in);
      b_r   <= magnitude(b_in);
      neg_r <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
    end
  end

  assign result = neg_r ? (~post_shift + ONE_2W) : post_shift;
`else
  // The operands are deliberately left out of rst. The controller holds rst
  // high while idle, and the operands are captured in that state.
  always_ff @(posedge clk) begin
    if (enableFFin) begin
      a_r <= a_in;
      b_r <= b_in;
    end
  end

  assign result = post_shift;
`endif

  assign done = (cnt == CNT_LAST);

  // This is the low 2*WIDTH bits of ({acc,lo} >> 1), i.e. the value that
  // {acc[WIDTH-1:0], lo} holds after this edge's shift.
  assign post_shift = {acc, lo[WIDTH-1:1]};

  assign capture = !rst && !enableFijo && shift && done;

  // Exactly one action per edge: rst > enableFijo > shift > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      lo  <= '0;
      cnt <= '0;
    end else if (enableFijo) begin
      acc <= '0;
      lo  <= b_r;
      cnt <= '0;
    end else if (shift) begin
      acc <= {1'b0, acc[WIDTH:1]};
      lo  <= {acc[0], lo[WIDTH-1:1]};
      // A shift past the final iteration still moves the data, but the
      // counter stops so that done cannot fire again.
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end else if (load) begin
      if (lo[0]) begin
        acc <= acc + {1'b0, a_r};
      end
    end
  end

  // The result survives rst, so it stays readable while the controller idles.
  always_ff @(posedge clk) begin
    if (capture) begin
      product <= result;
    end
  end

endmodule

// File: tb/tb_shift_add_datapath.sv
module tb_shift_add_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           enableFFin;
  logic           enableFijo;
  logic           load;
  logic           shift;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           done;
  logic [2*W-1:0] product;

  int             errors = 0;
  int             checks = 0;
  logic           have_prev = 1'b0;
  logic [2*W-1:0] prev_p = '0;

  shift_add_datapath #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enableFFin (enableFFin),
    .enableFijo (enableFijo),
    .load       (load),
    .shift      (shift),
    .a_in       (a_in),
    .b_in       (b_in),
    .done       (done),
    .product    (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are read at the same point.
  task automatic step(input logic r, input logic ff, input logic fj,
                      input logic ld, input logic sh);
    rst = r; enableFFin = ff; enableFijo = fj; load = ld; shift = sh;
    @(posedge clk);
    #1;
  endtask

  // Full FSM sequence. Cycle n is the interval just after edge n.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cap, input logic [2*W-1:0] exp_p,
                         input string nm);
    logic [2*W+1:0] mask;
    logic [2*W+1:0] exp_mask;
    mask = '0;
    a_in = a;
    b_in = b;
    step(1'b1, cap, 1'b0, 1'b0, 1'b0);
    mask[0] = done;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mask[1] = done;
    for (int k = 1; k <= W; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      mask[2*k] = done;
      if (k == W && have_prev) chk({nm, "_hold"}, 32'(product), 32'(prev_p));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mask[2*k+1] = done;
    end
    exp_mask = '0;
    exp_mask[2*W-1] = 1'b1;
    exp_mask[2*W]   = 1'b1;
    chk({nm, "_done_timing"}, 32'(mask), 32'(exp_mask));
    chk({nm, "_product"}, 32'(product), 32'(exp_p));
    prev_p    = exp_p;
    have_prev = 1'b1;
  endtask

  initial begin
    int             dseen;
    logic [2*W-1:0] held;

`ifdef SIGNED_OPERANDS_EN
    vecs[0] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'hFF, 8'h7F, 16'hFF81};
    vecs[3] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[4] = '{8'h00, 8'hC8, 16'h0000};
    vecs[5] = '{8'h80, 8'h01, 16'hFF80};
`else
    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   16'h0000};
    vecs[4] = '{8'd1,   8'd255, 16'h00FF};
    vecs[5] = '{8'd128, 8'd2,   16'h0100};
`endif

    a_in = '0;
    b_in = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_done", 32'(done), 32'd0);

    foreach (vecs[i]) run_mul(vecs[i].a, vecs[i].b, 1'b1, vecs[i].p, $sformatf("vec%0d", i));

    // Idle with rst held high: the result and done must not move.
    run_mul(8'd13, 8'd11, 1'b1, 16'h008F, "m13x11");
    dseen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (done) dseen++;
    end
    chk("rst_hold_done", 32'(dseen), 32'd0);
    chk("rst_hold_product", 32'(product), 32'h008F);

    // Reset after the 3rd shift.
    a_in = 8'd7;
    b_in = 8'd9;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst3_done", 32'(done), 32'd0);
    chk("midrst3_product", 32'(product), 32'h008F);

    // Reset while done is high.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < W - 1; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("midrst7_done_before", 32'(done), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst7_done_after", 32'(done), 32'd0);
    chk("midrst7_product", 32'(product), 32'h008F);

    // Rerun without a new capture. This relies on the operands surviving rst.
    a_in = 8'd0;
    b_in = 8'd0;
    run_mul(8'd0, 8'd0, 1'b0, 16'h003F, "rerun7x9");

    // shift + load in one cycle: only the shift is applied. Multiplier bit 0 is skipped, so 5*2.
    a_in = 8'd5;
    b_in = 8'd3;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < W - 1; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("overlap_shift_load", 32'(product), 32'h000A);

    // enableFijo + shift: only the init is applied. A full run of 8 pairs follows.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("overlap_init_done", 32'(done), 32'd0);
    for (int k = 0; k < W; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("overlap_init_shift", 32'(product), 32'h000F);

    // Extra shifts past the end: cnt saturates, so done never fires and product holds.
    held  = product;
    dseen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (done) dseen++;
    end
    chk("sat_done", 32'(dseen), 32'd0);
    chk("sat_product", 32'(product), 32'(held));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
